load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the EX/MEM pipeline register and the byte-addressed, big-endian, synchronous-read data memory. Converts MIPS load/store ops (LB/LBU/LH/LHU/LW/SB/SH/SW) into word-aligned memory transactions. Performs read-modify-write for sub-word stores and lane extraction plus sign/zero extension for loads. Stalls the pipeline while a transaction is in flight.

## Interface
- ADDR_SIZE, 32, byte address width
- WORD_WIDTH, 32, data word width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present from EX/MEM
- req_op  in  3  LB=000, LH=001, LW=010, SW=011, LBU=100, LHU=101, SB=110, SH=111
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  WORD_WIDTH  store data, right-justified for SB/SH
- mem_read  out  1  to data memory MemRead
- mem_write  out  1  to data memory MemWrite
- mem_addr  out  ADDR_SIZE  always {req_addr[31:2],2'b00} of the active op
- mem_wdata  out  WORD_WIDTH  full word to write
- mem_rdata  in  WORD_WIDTH  memory read data, valid the cycle after mem_read
- stall  out  1  hold EX/MEM and upstream this cycle
- load_valid  out  1  one-cycle pulse, load_data valid
- load_data  out  WORD_WIDTH  extended load result
- misalign_err  out  1  one-cycle pulse, access suppressed

## Operation
- FSM states: IDLE, LOAD_RSP, MERGE. Requests are accepted only in IDLE; req_* is ignored in LOAD_RSP/MERGE.
- On accept, op, byte offset addr[1:0], word address and wdata are captured into internal registers. Response states use only the captured values.
- Loads (IDLE, req_valid): mem_read=1, stall=1, go to LOAD_RSP. In LOAD_RSP: select lane from mem_rdata, extend, register into load_data, load_valid=1, stall=0, return to IDLE.
- Lane mapping is big-endian: byte offset k occupies mem_rdata[31-8k -: 8]. Halfword offset 0 is [31:16]; offset 2 is [15:0].
- LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- SW: single cycle. mem_write=1, mem_wdata=req_wdata, stall=0, remain in IDLE.
- SB/SH: IDLE issues mem_read, stall=1, go to MERGE. MERGE replaces the addressed lane(s) of mem_rdata with wdata[7:0] or wdata[15:0], issues mem_write with the merged word, stall=0, returns to IDLE.
- mem_read and mem_write are never both high in one cycle.
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): no memory strobe, misalign_err=1 that cycle, stall=0, remain in IDLE.
- Idle with req_valid=0: all strobes 0, stall=0.
- load_data holds its last value between loads.

## Timing
- Reset values: state=IDLE, load_data=0, load_valid=0, captured regs=0. mem_read, mem_write, stall and misalign_err are 0, since they are combinational from IDLE with no request.
- Load latency: accept cycle N, load_valid and load_data at N+1. Exactly one stall cycle.
- SW: write at edge ending cycle N. Zero stall.
- SB/SH: read at N, write at N+1. One stall cycle.
- Back-to-back: a new request can be accepted in the cycle after a response state, so throughput is one load per 2 cycles.
- Reset asserted in LOAD_RSP or MERGE: returns to IDLE asynchronously. No pending write is issued and load_valid stays 0.
- Outputs mem_* and stall are combinational from state and inputs. load_data and load_valid are registered.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses are detected, suppressed, and reported on misalign_err as above.
- LSU_MISALIGN_TRAP_EN undefined: misalign_err is tied 0. Halfword offsets use addr[1] only and word ops ignore addr[1:0], so accesses are silently aligned down and proceed normally.

## Structure
- lsu_pkg holds:
  - the op typedef enum (3-bit encodings above), plus is_load/is_subword helper functions;
  - the FSM state typedef enum;
  - byte-lane constants.
- Sub-module lsu_extend (combinational): inputs word, offset and op; output is the extended load value. Instantiated once for the LOAD_RSP path.

## Test plan
- Memory word at 0x10 = 0x80FF_7F01. LB 0x10 → load_data 0xFFFF_FF80. LBU 0x11 → 0x0000_00FF. LH 0x12 → 0x0000_7F01. Each is preceded by one stall cycle.
- SW 0x20 data 0x1234_5678 → mem_write in the same cycle, stall=0. Then LW 0x20 → 0x1234_5678 at N+1.
- Word 0x20 = 0x1234_5678, SB 0x21 data 0xAB → read at N, write 0x12AB_5678 at N+1. A following SH 0x22 data 0xCDEF → 0x12AB_CDEF.
- LW 0x22 (TRAP_EN defined) → misalign_err=1, mem_read=0, stall=0. Without the macro → reads word 0x20, no error.
- Reset asserted while in MERGE for SB 0x21 → no mem_write. Word 0x20 is unchanged and state returns to IDLE.
- Back-to-back LW 0x20, LW 0x24 → accepts at N and N+2, load_valid at N+1 and N+3.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op encodings, FSM states,
// byte-lane geometry and alignment rules.
package lsu_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Big-endian lane offsets: the byte at offset 0 is the most significant.
  localparam logic [1:0] LANE_B0   = 2'd0;
  localparam logic [1:0] LANE_B1   = 2'd1;
  localparam logic [1:0] LANE_B2   = 2'd2;
  localparam logic [1:0] LANE_B3   = 2'd3;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_RSP,
    ST_MERGE
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_subword(input lsu_op_e op);
    return !(op inside {OP_LW, OP_SW});
  endfunction

  function automatic logic is_half(input lsu_op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    return (is_half(op) && off[0]) || (!is_subword(op) && (off != 2'b00));
  endfunction

  // Offset actually used for the access: halfwords drop bit 0, words drop both.
  function automatic logic [1:0] align_offset(input lsu_op_e op, input logic [1:0] off);
    if (!is_subword(op)) return 2'b00;
    if (is_half(op))     return {off[1], 1'b0};
    return off;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load lane extraction: picks the big-endian byte/halfword lane out of a memory
// word and sign- or zero-extends it according to the load op.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        offset,
  input  lsu_op_e           op,
  output logic [WORD_W-1:0] ext
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_v = word[31:24];
    unique case (offset)
      LANE_B0: byte_v = word[31:24];
      LANE_B1: byte_v = word[23:16];
      LANE_B2: byte_v = word[15:8];
      LANE_B3: byte_v = word[7:0];
    endcase
    half_v = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    ext = word;
    unique case (op)
      OP_LB:   ext = {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
      OP_LBU:  ext = {{(WORD_W-BYTE_W){1'b0}}, byte_v};
      OP_LH:   ext = {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
      OP_LHU:  ext = {{(WORD_W-HALF_W){1'b0}}, half_v};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit between EX/MEM and a big-endian synchronous-read memory.
// Define LSU_MISALIGN_TRAP_EN to suppress and flag misaligned accesses instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [WORD_WIDTH-1:0] load_data,
  output logic                  misalign_err
);

  lsu_state_e            state;
  lsu_op_e               op_q;
  logic [1:0]            off_q;
  logic [ADDR_SIZE-1:0]  waddr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] load_data_q;
  logic [WORD_WIDTH-1:0] ext_word;
  logic [WORD_WIDTH-1:0] merged;

  lsu_op_e              op_in;
  logic                 misaligned;
  logic                 accept;
  logic [ADDR_SIZE-1:0] req_waddr;

  assign op_in     = lsu_op_e'(req_op);
  assign req_waddr = {req_addr[ADDR_SIZE-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = req_valid && is_misaligned(op_in, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && req_valid && !misaligned;

  lsu_extend u_extend (
    .word   (mem_rdata),
    .offset (off_q),
    .op     (op_q),
    .ext    (ext_word)
  );

  // Memory data arrives during LOAD_RSP, so the result is forwarded that cycle and held afterwards.
  assign load_data = load_valid ? ext_word : load_data_q;

  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      unique case (off_q)
        LANE_B0: merged[31:24] = wdata_q[7:0];
        LANE_B1: merged[23:16] = wdata_q[7:0];
        LANE_B2: merged[15:8]  = wdata_q[7:0];
        LANE_B3: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = req_waddr;
    mem_wdata    = req_wdata;
    stall        = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            misalign_err = 1'b1;
          end else if (op_in == OP_SW) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
          end
        end
      end
      ST_LOAD_RSP: mem_addr = waddr_q;
      ST_MERGE: begin
        mem_addr  = waddr_q;
        mem_write = 1'b1;
        mem_wdata = merged;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously to a known IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_LB;
      off_q       <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= '0;
      load_valid  <= 1'b0;
      load_data_q <= '0;
    end else begin
      load_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            off_q   <= align_offset(op_in, req_addr[1:0]);
            waddr_q <= req_waddr;
            wdata_q <= req_wdata;
            if (is_load(op_in)) begin
              state      <= ST_LOAD_RSP;
              load_valid <= 1'b1;
            end else if (is_subword(op_in)) begin
              state <= ST_MERGE;
            end
          end
        end
        ST_LOAD_RSP: begin
          load_data_q <= ext_word;
          state       <= ST_IDLE;
        end
        ST_MERGE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random ops
// checked against a word-array reference model of big-endian load/store semantics.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SW = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SB = 3'b110, SH = 3'b111;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_read, mem_write, stall, load_valid, misalign_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [31:0] mem_rdata = '0;

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read)  mem_rdata <= dmem[mem_addr[7:2]];
    if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] a);
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    if (op == LW || op == SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int ref_off(input logic [2:0] op, input logic [31:0] a);
    int k = int'(a % 4);
    if (op == LW || op == SW) return 0;
    if (op == LH || op == LHU || op == SH) return k - (k % 2);
    return k;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w = ref_mem[a[7:2]];
    int k = ref_off(op, a);
    logic [31:0] b = (w >> (8 * (3 - k))) & 32'hFF;
    logic [31:0] h = (w >> (8 * (2 - k))) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] wd);
    logic [31:0] old = ref_mem[a[7:2]];
    int k = ref_off(op, a);
    int sh;
    if (op == SB) begin
      sh = 8 * (3 - k);
      return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (op == SH) begin
      sh = 8 * (2 - k);
      return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // Issues one request starting just after a rising edge; returns the accept cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output int acc);
    bit mis, ld, sub;
    logic [31:0] exp_w;
    mis = TRAP && ref_mis(op, a);
    ld  = op inside {LB, LH, LW, LBU, LHU};
    sub = (op == SB) || (op == SH);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    acc = cyc;
    #1;
    check("acc_misalign_err", misalign_err, mis);
    check("acc_stall", stall, !mis && (ld || sub));
    check("acc_mem_read", mem_read, !mis && (ld || sub));
    check("acc_mem_write", mem_write, !mis && (op == SW));
    if (!mis) check("acc_mem_addr", mem_addr, {a[31:2], 2'b00});
    if (!mis && op == SW) check("sw_wdata", mem_wdata, wd);
    @(posedge clk); #1;
    if (!mis && op == SW) ref_mem[a[7:2]] = wd;
    if (!mis && (ld || sub)) begin
      // Garbage request during the response cycle must be ignored.
      req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      #1;
      check("rsp_stall", stall, 0);
      check("rsp_mem_read", mem_read, 0);
      check("rsp_misalign_err", misalign_err, 0);
      if (ld) begin
        check("rsp_load_valid", load_valid, 1);
        check("rsp_load_data", load_data, ref_load(op, a));
        check("rsp_mem_write", mem_write, 0);
      end else begin
        exp_w = ref_store(op, a, wd);
        check("merge_mem_write", mem_write, 1);
        check("merge_mem_addr", mem_addr, {a[31:2], 2'b00});
        check("merge_mem_wdata", mem_wdata, exp_w);
        check("merge_load_valid", load_valid, 0);
      end
      @(posedge clk); #1;
      if (sub) ref_mem[a[7:2]] = exp_w;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int acc, acc2, bad;
    logic [2:0] rop;
    logic [31:0] ra;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[4] = 32'h80FF_7F01;
    ref_mem[4] = 32'h80FF_7F01;

    repeat (2) @(posedge clk);
    #1;
    check("rst_load_valid", load_valid, 0);
    check("rst_load_data", load_data, 0);
    check("rst_stall", stall, 0);
    check("rst_strobes", {mem_read, mem_write, misalign_err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_strobes", {mem_read, mem_write, stall, misalign_err}, 0);

    run_op(LB, 32'h10, 32'h0, acc);
    check("plan_lb", load_data, 32'hFFFF_FF80);
    check("hold_load_valid", load_valid, 0);
    run_op(LBU, 32'h11, 32'h0, acc);
    check("plan_lbu", load_data, 32'h0000_00FF);
    run_op(LH, 32'h12, 32'h0, acc);
    check("plan_lh", load_data, 32'h0000_7F01);
    @(posedge clk); #1;
    check("hold_load_data", load_data, 32'h0000_7F01);

    run_op(SW, 32'h20, 32'h1234_5678, acc);
    check("plan_sw_mem", dmem[8], 32'h1234_5678);
    run_op(LW, 32'h20, 32'h0, acc);
    check("plan_lw", load_data, 32'h1234_5678);
    run_op(SB, 32'h21, 32'h0000_00AB, acc);
    check("plan_sb_mem", dmem[8], 32'h12AB_5678);
    run_op(SH, 32'h22, 32'h0000_CDEF, acc);
    check("plan_sh_mem", dmem[8], 32'h12AB_CDEF);
    run_op(LW, 32'h22, 32'h0, acc);
    check("plan_lw_misaligned", load_data, TRAP ? 32'h1234_5678 : 32'h12AB_CDEF);

    // Reset while in MERGE: the pending write must vanish.
    req_valid = 1'b1; req_op = SB; req_addr = 32'h21; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("merge_before_rst", mem_write, 1);
    rst = 1'b1; #1;
    check("merge_rst_mem_write", mem_write, 0);
    check("merge_rst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("merge_rst_mem", dmem[8], 32'h12AB_CDEF);
    run_op(LW, 32'h20, 32'h0, acc);
    check("post_rst_lw", load_data, 32'h12AB_CDEF);

    // Reset while in LOAD_RSP: no load_valid, load_data cleared.
    req_valid = 1'b1; req_op = LW; req_addr = 32'h24; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1; #1;
    check("load_rsp_rst_valid", load_valid, 0);
    check("load_rsp_rst_data", load_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back loads: accepts two cycles apart.
    run_op(LW, 32'h20, 32'h0, acc);
    run_op(LW, 32'h24, 32'h0, acc2);
    check("b2b_spacing", acc2 - acc, 2);

    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom_range(0, 255);
      run_op(rop, ra, $urandom, acc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("rand_idle_strobes", {mem_read, mem_write, stall, misalign_err, load_valid}, 0);
      end
    end

    bad = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) bad++;
    check("final_mem_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
